// File: rtl/sha1_core.sv
// ---------------------------------------------------------------------------
// sha1_core
//
// Iterative SHA-1 engine. It performs one compression round per clock and
// hashes NUM_BLOCKS pre-padded 512-bit blocks for each start request.
//
// Ports
//   clk       rising-edge clock for all state
//   rst_n     asynchronous, active-low reset
//   start     single-cycle request to hash block_in; ignored while busy=1
//   block_in  pre-padded message; word j is block_in[32j+31:32j], and the
//             first message byte of each word sits in bits [31:24]
//   digest    final hash, H0 in [31:0] up to H4 in [159:128]; held until the
//             next done
//   done      one-cycle pulse, digest valid in the same cycle
//   busy      high while a hash is in progress
//
// Timing: start sampled at edge 0 gives done after edge 81*NUM_BLOCKS.
// Each block takes 80 round cycles plus one ADD cycle. A start in the done
// cycle is accepted, so back-to-back hashes have a period of
// 81*NUM_BLOCKS+1 cycles.
// ---------------------------------------------------------------------------
module sha1_core #(
   parameter int NUM_BLOCKS = 2
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   input  logic [512*NUM_BLOCKS-1:0] block_in,
   output logic [159:0]              digest,
   output logic                      done,
   output logic                      busy
);

   localparam int         BLK_W    = 512 * NUM_BLOCKS;
   localparam logic [1:0] LAST_BLK = 2'(NUM_BLOCKS - 1);

   localparam logic [31:0] H0_INIT = 32'h67452301;
   localparam logic [31:0] H1_INIT = 32'hEFCDAB89;
   localparam logic [31:0] H2_INIT = 32'h98BADCFE;
   localparam logic [31:0] H3_INIT = 32'h10325476;
   localparam logic [31:0] H4_INIT = 32'hC3D2E1F0;

   localparam logic [31:0] K_0 = 32'h5A827999;
   localparam logic [31:0] K_1 = 32'h6ED9EBA1;
   localparam logic [31:0] K_2 = 32'h8F1BBCDC;
   localparam logic [31:0] K_3 = 32'hCA62C1D6;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ROUND = 2'd1,
      ADD   = 2'd2
   } state_t;

   state_t            state_reg;
   logic [BLK_W-1:0]  block_reg;     // message captured at start
   logic [31:0]       w_reg [0:15];  // circular message schedule
   logic [31:0]       a_reg, b_reg, c_reg, d_reg, e_reg;
   logic [31:0]       h0_reg, h1_reg, h2_reg, h3_reg, h4_reg;
   logic [6:0]        t_reg;         // round counter 0..79
   logic [1:0]        blk_reg;       // index of the block being hashed

   // ------------------------------------------------------------------
   // Message schedule
   // The 16-entry buffer holds W[t-16..t-1]. Slot t mod 16 holds W[t-16]
   // until it is overwritten with W[t] in round t, so the taps for
   // t-3, t-8 and t-14 sit at offsets +13, +8 and +2 modulo 16.
   // ------------------------------------------------------------------
   logic [3:0]  t_idx;
   logic [3:0]  idx_m3;
   logic [3:0]  idx_m8;
   logic [3:0]  idx_m14;
   logic [31:0] w_mix;
   logic [31:0] w_cur;

   assign t_idx   = t_reg[3:0];
   assign idx_m3  = t_idx + 4'd13;
   assign idx_m8  = t_idx + 4'd8;
   assign idx_m14 = t_idx + 4'd2;

   always_comb begin
      w_mix = w_reg[idx_m3] ^ w_reg[idx_m8] ^ w_reg[idx_m14] ^ w_reg[t_idx];
      if (t_reg < 7'd16) begin
         w_cur = w_reg[t_idx];
      end else begin
         w_cur = {w_mix[30:0], w_mix[31]};
      end
   end

   // ------------------------------------------------------------------
   // Round function and constant
   // ------------------------------------------------------------------
   logic [31:0] f_val;
   logic [31:0] k_val;
   logic [31:0] temp;

   always_comb begin
      f_val = b_reg ^ c_reg ^ d_reg;
      k_val = K_1;
      if (t_reg < 7'd20) begin
         f_val = (b_reg & c_reg) | (~b_reg & d_reg);
         k_val = K_0;
      end else if (t_reg < 7'd40) begin
         f_val = b_reg ^ c_reg ^ d_reg;
         k_val = K_1;
      end else if (t_reg < 7'd60) begin
         f_val = (b_reg & c_reg) | (b_reg & d_reg) | (c_reg & d_reg);
         k_val = K_2;
      end else begin
         f_val = b_reg ^ c_reg ^ d_reg;
         k_val = K_3;
      end
   end

   // Sums wrap modulo 2^32 because the target is 32 bits wide.
   assign temp = {a_reg[26:0], a_reg[31:27]} + f_val + e_reg + k_val + w_cur;

   // Chaining-value update used in ADD.
   logic [31:0] h0_sum, h1_sum, h2_sum, h3_sum, h4_sum;

   assign h0_sum = h0_reg + a_reg;
   assign h1_sum = h1_reg + b_reg;
   assign h2_sum = h2_reg + c_reg;
   assign h3_sum = h3_reg + d_reg;
   assign h4_sum = h4_reg + e_reg;

   // ------------------------------------------------------------------
   // Word views of the incoming message and of the next stored block.
   // A shift brings the next block down to bit 0, so the block index
   // never needs a variable part-select.
   // ------------------------------------------------------------------
   logic [1:0]   blk_inc;
   logic [10:0]  next_shift;
   logic [511:0] next_block;
   logic [31:0]  start_word [0:15];
   logic [31:0]  next_word  [0:15];

   assign blk_inc    = blk_reg + 2'd1;
   assign next_shift = {blk_inc, 9'd0};
   assign next_block = 512'(block_reg >> next_shift);

   for (genvar gi = 0; gi < 16; gi++) begin : g_words
      assign start_word[gi] = block_in[32*gi +: 32];
      assign next_word[gi]  = next_block[32*gi +: 32];
   end

   // ------------------------------------------------------------------
   // Control FSM and datapath registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         block_reg <= '0;
         for (int i = 0; i < 16; i++) begin
            w_reg[i] <= '0;
         end
         a_reg     <= '0;
         b_reg     <= '0;
         c_reg     <= '0;
         d_reg     <= '0;
         e_reg     <= '0;
         h0_reg    <= '0;
         h1_reg    <= '0;
         h2_reg    <= '0;
         h3_reg    <= '0;
         h4_reg    <= '0;
         t_reg     <= '0;
         blk_reg   <= '0;
         digest    <= '0;
         done      <= 1'b0;
         busy      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (start) begin
                  block_reg <= block_in;
                  for (int i = 0; i < 16; i++) begin
                     w_reg[i] <= start_word[i];
                  end
                  h0_reg    <= H0_INIT;
                  h1_reg    <= H1_INIT;
                  h2_reg    <= H2_INIT;
                  h3_reg    <= H3_INIT;
                  h4_reg    <= H4_INIT;
                  a_reg     <= H0_INIT;
                  b_reg     <= H1_INIT;
                  c_reg     <= H2_INIT;
                  d_reg     <= H3_INIT;
                  e_reg     <= H4_INIT;
                  t_reg     <= '0;
                  blk_reg   <= '0;
                  busy      <= 1'b1;
                  state_reg <= ROUND;
               end
            end

            ROUND: begin
               // For t<16 this rewrites the same word; afterwards it
               // replaces W[t-16] with W[t].
               w_reg[t_idx] <= w_cur;
               e_reg        <= d_reg;
               d_reg        <= c_reg;
               c_reg        <= {b_reg[1:0], b_reg[31:2]};
               b_reg        <= a_reg;
               a_reg        <= temp;
               t_reg        <= t_reg + 7'd1;
               if (t_reg == 7'd79) begin
                  state_reg <= ADD;
               end
            end

            ADD: begin
               h0_reg <= h0_sum;
               h1_reg <= h1_sum;
               h2_reg <= h2_sum;
               h3_reg <= h3_sum;
               h4_reg <= h4_sum;
               if (blk_reg != LAST_BLK) begin
                  a_reg   <= h0_sum;
                  b_reg   <= h1_sum;
                  c_reg   <= h2_sum;
                  d_reg   <= h3_sum;
                  e_reg   <= h4_sum;
                  for (int i = 0; i < 16; i++) begin
                     w_reg[i] <= next_word[i];
                  end
                  blk_reg   <= blk_inc;
                  t_reg     <= '0;
                  state_reg <= ROUND;
               end else begin
                  digest    <= {h4_sum, h3_sum, h2_sum, h1_sum, h0_sum};
                  done      <= 1'b1;
                  busy      <= 1'b0;
                  state_reg <= IDLE;
               end
            end

            default: begin
               state_reg <= IDLE;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/sha1_core.md
SHA1_CORE -- requirements
Module: sha1_core

Interface
REQ-001 The module SHALL have parameter NUM_BLOCKS, default 2, giving the number of 512-bit SHA-1 blocks hashed per start (legal values 1..4).
REQ-002 Port clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 Port rst_n  input  1  reset; SHALL be asynchronous and active-low.
REQ-004 Port start  input  1  single-cycle request to hash block_in; sampled only while busy=0.
REQ-005 Port block_in  input  512*NUM_BLOCKS  pre-padded message; message word j SHALL be block_in[32j+31:32j]; block k SHALL be words 16k..16k+15.
REQ-006 Within each word, the first message byte SHALL occupy bits [31:24] (big-endian).
REQ-007 Port digest  output  160  final hash; H0 SHALL be digest[31:0], H1 [63:32], H2 [95:64], H3 [127:96], H4 [159:128].
REQ-008 Port done  output  1  one-cycle pulse; digest is valid in the same cycle.
REQ-009 Port busy  output  1  high while a hash is in progress.

Function
REQ-010 All outputs SHALL be registered.
REQ-011 States SHALL be IDLE, ROUND, ADD.
REQ-012 IDLE with start=1 SHALL, at that edge:
  - latch block_in;
  - set H0..H4 = 67452301, EFCDAB89, 98BADCFE, 10325476, C3D2E1F0;
  - load a..e from those constants;
  - set block index = 0 and round counter t = 0;
  - go to ROUND with busy=1.
REQ-013 ROUND SHALL execute exactly one SHA-1 round per clock for t = 0..79, with a 16-word circular message schedule:
  - W[t] = message word for t<16;
  - W[t] = rotl1(W[t-3]^W[t-8]^W[t-14]^W[t-16]) for t>=16.
REQ-014 Round functions and constants:
  - t 0-19: f = (b&c)|(~b&d), K = 5A827999;
  - t 20-39: f = b^c^d, K = 6ED9EBA1;
  - t 40-59: f = (b&c)|(b&d)|(c&d), K = 8F1BBCDC;
  - t 60-79: f = b^c^d, K = CA62C1D6.
REQ-015 Round update: temp = rotl5(a)+f+e+K+W[t] mod 2^32; then e=d, d=c, c=rotl30(b), b=a, a=temp.
REQ-016 After the round with t=79, the module SHALL go to ADD.
REQ-017 ADD SHALL take one cycle and set Hi += {a,b,c,d,e}[i] mod 2^32.
REQ-018 In ADD, if block index < NUM_BLOCKS-1, the module SHALL:
  - reload a..e from the updated H;
  - load the next block's 16 words into the schedule;
  - increment block index, clear t, and return to ROUND.
REQ-019 In ADD for the last block, the module SHALL:
  - register digest from the updated H;
  - pulse done=1 for one cycle with busy=0 in that same cycle;
  - go to IDLE.
REQ-020 Latency: with start sampled at edge 0, done and digest SHALL be high/valid after edge 81*NUM_BLOCKS (162 for the default).
REQ-021 digest SHALL hold its value until the next done.
REQ-022 start while busy=1 SHALL be ignored, with no effect on the hash in progress.
REQ-023 start in the cycle done=1 (busy=0) SHALL be accepted; back-to-back hashes SHALL therefore have a period of 81*NUM_BLOCKS+1 cycles.
REQ-024 block_in changes after the start edge SHALL NOT affect the result.
REQ-025 All additions SHALL wrap modulo 2^32 with no carry out.

Reset
REQ-026 rst_n=0 SHALL asynchronously force:
  - state=IDLE;
  - digest=0, done=0, busy=0;
  - a..e, H0..H4, schedule, t and block index = 0.
REQ-027 Reset asserted mid-hash SHALL abort the hash; no done SHALL be produced for it.
REQ-028 After rst_n deasserts, the first start SHALL be accepted on the first rising edge.

Verification
REQ-029 NUM_BLOCKS=2, 448-bit message "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" padded to 1024 bits -> done at edge 162 with digest[31:0]=84983E44, [63:32]=1C3BD26E, [95:64]=BAAE4AA1, [127:96]=F95129E5, [159:128]=E54670F1.
REQ-030 NUM_BLOCKS=1, message "abc" padded -> done at edge 81 with digest H0..H4 = A9993E36, 4706816A, BA3E2571, 7850C26C, 9CD0D89D.
REQ-031 Second start pulse at edge 50 of a running hash, carrying a different block_in -> digest unchanged from the REQ-029 value; exactly one done.
REQ-032 start asserted in the done cycle, using the REQ-030 padded "abc" message with NUM_BLOCKS=2 -> second done exactly 163 cycles after the first; both digests match a software SHA-1 model.
REQ-033 rst_n pulsed low at edge 100 -> done, busy and digest go to 0 immediately; no done follows; a new start yields the REQ-029 digest at edge +162.
REQ-034 block_in driven with random data on every cycle after the start edge -> digest equals the hash of the block_in value sampled at start.
